// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg
//   Shared definitions for the multi-channel debouncer: one-hot state
//   encoding for the per-channel FSM and default qualification lengths
//   for the supported board clocks (20 ms window).
package multi_debouncer_pkg;

  // One-hot, so any corrupted encoding is detectable and can be recovered
  typedef enum logic [3:0] {
    ST_STABLE_LO = 4'b0001,
    ST_PEND_HI   = 4'b0010,
    ST_STABLE_HI = 4'b0100,
    ST_PEND_LO   = 4'b1000
  } deb_state_t;

  localparam int DEB_CYC_25MHZ_20MS  = 500000;
  localparam int DEB_CYC_50MHZ_20MS  = 1000000;
  localparam int DEB_CYC_100MHZ_20MS = 2000000;  // needs CNT_W >= 21

  // Qualification length for a given clock (kHz) and window (ms)
  function automatic int deb_cycles(input int clk_khz, input int window_ms);
    return clk_khz * window_ms;
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// multi_debouncer_if
//   Bundles the per-channel raw inputs and conditioned outputs.
//   master : source of sig_in, consumer of sig_out/rise/fall/any_change
//   slave  : the debouncer itself
interface multi_debouncer_if #(
  parameter int N_CH = 8
);
  logic [N_CH-1:0] sig_in;
  logic [N_CH-1:0] sig_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic            any_change;

  modport master (output sig_in, input sig_out, rise, fall, any_change);
  modport slave  (input sig_in, output sig_out, rise, fall, any_change);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel
//   Synchronizer, stability counter and FSM for one mechanical input.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     sig_in      : raw asynchronous input
//     sig_out     : debounced level (registered)
//     rise, fall  : one-cycle pulses on sig_out edges (registered)
//     change_nxt  : value rise|fall will take on the next edge, so the
//                   parent can register an aggregate flag in step
//
//   state        | meaning
//   -------------+------------------------------------------------
//   ST_STABLE_LO | output low, synchronized input low
//   ST_PEND_HI   | output low, input high, counting toward accept
//   ST_STABLE_HI | output high, synchronized input high
//   ST_PEND_LO   | output high, input low, counting toward accept
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int   CNT_W           = 20,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic change_nxt
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam deb_state_t       ST_RST  = RESET_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  deb_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             sig_out_q, sig_out_nxt;
  logic             rise_q, rise_nxt;
  logic             fall_q, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register (also holds counter and registered outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      sig_out_q <= RESET_LEVEL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      sig_out_q <= sig_out_nxt;
      rise_q    <= rise_nxt;
      fall_q    <= fall_nxt;
    end
  end

  // Next-state and counter
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    case (state_q)
      ST_STABLE_LO: begin
        if (s) begin
          state_nxt = ST_PEND_HI;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PEND_HI: begin
        if (!s) begin
          state_nxt = ST_STABLE_LO;
        end else if (cnt_q == CNT_TC) begin
          state_nxt = ST_STABLE_HI;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE_HI: begin
        if (!s) begin
          state_nxt = ST_PEND_LO;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PEND_LO: begin
        if (s) begin
          state_nxt = ST_STABLE_HI;
        end else if (cnt_q == CNT_TC) begin
          state_nxt = ST_STABLE_LO;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      // Corrupted encoding: fall back to the stable state matching the
      // level already presented, so recovery never glitches sig_out.
      default: begin
        state_nxt = sig_out_q ? ST_STABLE_HI : ST_STABLE_LO;
      end
    endcase
  end

  // Outputs, computed one edge early and registered above
  always_comb begin
    sig_out_nxt = (state_nxt == ST_STABLE_HI) || (state_nxt == ST_PEND_LO);
    rise_nxt    = (state_q == ST_PEND_HI) && (state_nxt == ST_STABLE_HI);
    fall_nxt    = (state_q == ST_PEND_LO) && (state_nxt == ST_STABLE_LO);
  end

  assign sig_out    = sig_out_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign change_nxt = rise_nxt | fall_nxt;

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer
//   N_CH independent debounce channels plus a registered aggregate
//   change flag for the note/voice allocator.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     dbus       : slave side of multi_debouncer_if
//                  (sig_in in; sig_out, rise, fall, any_change out)
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int   N_CH            = 8,
  parameter int   CNT_W           = 20,
  parameter int   DEBOUNCE_CYCLES = DEB_CYC_50MHZ_20MS,
  parameter int   SYNC_STAGES     = 2,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_debouncer_if.slave   dbus
);

  logic [N_CH-1:0] sig_out_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] fall_w;
  logic [N_CH-1:0] change_nxt_w;
  logic            any_change_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (dbus.sig_in[i]),
      .sig_out    (sig_out_w[i]),
      .rise       (rise_w[i]),
      .fall       (fall_w[i]),
      .change_nxt (change_nxt_w[i])
    );
  end

  // Registered from the channels' next-edge pulses so it lines up
  // with rise/fall in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |change_nxt_w;
    end
  end

  assign dbus.sig_out    = sig_out_w;
  assign dbus.rise       = rise_w;
  assign dbus.fall       = fall_w;
  assign dbus.any_change = any_change_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench: two instances (RESET_LEVEL 0 and 1), N_CH=4,
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2. A new level first sampled on
// tick 1 must appear on sig_out (with its pulse) on tick 6.
module tb_multi_debouncer;

  localparam int N_CH = 4;

  logic clk;
  logic rst_n0;
  logic rst_n1;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rise1_seen = 1'b0;
  logic overlap0_seen = 1'b0;
  logic [7:0] bounce_pat;

  multi_debouncer_if #(.N_CH(N_CH)) bus0 ();
  multi_debouncer_if #(.N_CH(N_CH)) bus1 ();

  multi_debouncer #(
    .N_CH(N_CH), .CNT_W(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n0), .dbus(bus0)
  );

  multi_debouncer #(
    .N_CH(N_CH), .CNT_W(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n1), .dbus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst_n1 && bus1.rise != '0) rise1_seen = 1'b1;
    if ((bus0.rise & bus0.fall) != '0) overlap0_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus0(input string tag, input int n, input logic [3:0] e_out,
                            input logic [3:0] e_rise, input logic [3:0] e_fall, input logic e_any);
    check($sformatf("%s_out_%0d", tag, n),  32'(bus0.sig_out),    32'(e_out));
    check($sformatf("%s_rise_%0d", tag, n), 32'(bus0.rise),       32'(e_rise));
    check($sformatf("%s_fall_%0d", tag, n), 32'(bus0.fall),       32'(e_fall));
    check($sformatf("%s_any_%0d", tag, n),  32'(bus0.any_change), 32'(e_any));
  endtask

  initial begin
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    bus0.sig_in = 4'h0;
    bus1.sig_in = 4'hF;
    #12;
    check_bus0("reset0", 0, 4'h0, 4'h0, 4'h0, 1'b0);
    check("reset1_out", 32'(bus1.sig_out), 32'hF);
    check("reset1_any", 32'(bus1.any_change), 32'h0);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check_bus0("idle0", n, 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // Clean step on channel 0
    bus0.sig_in[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check_bus0("clean", n, (n >= 6) ? 4'b0001 : 4'b0000,
                 (n == 6) ? 4'b0001 : 4'b0000, 4'b0000, n == 6);
    end

    // Bounce on channel 1: 1,1,0,1,1,1,1,1 then held
    bounce_pat = 8'b1111_1011;
    for (int n = 1; n <= 11; n++) begin
      bus0.sig_in[1] = (n <= 8) ? bounce_pat[n-1] : 1'b1;
      tick();
      check_bus0("bounce", n, (n >= 9) ? 4'b0011 : 4'b0001,
                 (n == 9) ? 4'b0010 : 4'b0000, 4'b0000, n == 9);
    end

    // Glitch on channel 2: high for 3 samples only
    for (int n = 1; n <= 10; n++) begin
      bus0.sig_in[2] = (n <= 3);
      tick();
      check_bus0("glitch", n, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    end

    // Channel 0 falls and channel 3 rises together
    bus0.sig_in[0] = 1'b0;
    bus0.sig_in[3] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check_bus0("simul", n, (n >= 6) ? 4'b1010 : 4'b0011,
                 (n == 6) ? 4'b1000 : 4'b0000,
                 (n == 6) ? 4'b0001 : 4'b0000, n == 6);
    end

    // Async reset with channel 0 in PEND_HI at count 2
    bus0.sig_in[0] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_bus0("pend", n, 4'b1010, 4'b0000, 4'b0000, 1'b0);
    end
    #2;
    rst_n0 = 1'b0;
    #1;
    check_bus0("async_rst", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check_bus0("post_rst", n, (n >= 6) ? 4'b1011 : 4'b0000,
                 (n == 6) ? 4'b1011 : 4'b0000, 4'b0000, n == 6);
    end

    // RESET_LEVEL=1 instance: channel 0 falls
    check("rl1_hold_out", 32'(bus1.sig_out), 32'hF);
    bus1.sig_in[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check($sformatf("rl1_out_%0d", n),  32'(bus1.sig_out), 32'((n >= 6) ? 4'b1110 : 4'b1111));
      check($sformatf("rl1_fall_%0d", n), 32'(bus1.fall),    32'((n == 6) ? 4'b0001 : 4'b0000));
      check($sformatf("rl1_rise_%0d", n), 32'(bus1.rise),    32'h0);
      check($sformatf("rl1_any_%0d", n),  32'(bus1.any_change), 32'(n == 6));
    end

    check("rl1_no_rise_ever", 32'(rise1_seen), 32'h0);
    check("rise_fall_overlap", 32'(overlap0_seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
